bsg_arb_fixed_n_to_1_buffered: RTL and testbench

// - Fixed-priority N-to-1 merger with a one-entry registered output.
// - Each cycle, picks one valid requester with a fixed-priority arbiter
//   (lo_to_hi_p selects the direction), dequeues it with yumi_o, and loads its

---
 rtl/bsg_arb_fixed_n_to_1_buffered.sv | 122 ++++++++++++
 tb/tb_bsg_arb_fixed_n_to_1_buffered.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/bsg_arb_fixed_n_to_1_buffered.sv
// Fixed-priority N-to-1 merger feeding a one-entry output register.
// Producers use valid/yumi; the consumer side is valid/ready.

module bsg_arb_fixed_n_to_1_buffered_lane #(
  parameter int width_p = 32
) (
  input  logic               i_v,
  input  logic               i_hi_any,
  input  logic [width_p-1:0] i_data,
  output logic               o_grant,
  output logic               o_any,
  output logic [width_p-1:0] o_data
);
  // A lane wins when it is valid and no higher-priority lane is.
  assign o_grant = i_v & ~i_hi_any;
  assign o_any   = i_v | i_hi_any;
  assign o_data  = o_grant ? i_data : '0;
endmodule

module bsg_arb_fixed_n_to_1_buffered #(
  parameter int inputs_p   = 16,
  parameter int width_p    = 32,
  parameter int lo_to_hi_p = 0,
  localparam int tag_width_lp = (inputs_p > 1) ? $clog2(inputs_p) : 1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic [inputs_p-1:0]           v_i,
  input  logic [inputs_p*width_p-1:0]   data_i,
  output logic [inputs_p-1:0]           yumi_o,
  output logic                          v_o,
  output logic [width_p-1:0]            data_o,
  output logic [tag_width_lp-1:0]       tag_o,
  input  logic                          ready_i
);

  logic [inputs_p-1:0][width_p-1:0] w_data_in;
  logic [inputs_p-1:0][width_p-1:0] w_data_msk;
  logic [inputs_p-1:0]              w_grant;
  logic [inputs_p:0]                w_chain;
  logic                             w_any;
  logic                             w_enq_ok;
  logic                             w_load;
  logic [width_p-1:0]               w_data_sel;
  logic [tag_width_lp-1:0]          w_tag_sel;

  logic                             r_v;
  logic [width_p-1:0]               r_data;
  logic [tag_width_lp-1:0]          r_tag;

  assign w_data_in = data_i;

  // Priority chain ripples from the favoured end; the far end carries "any valid".
  generate
    if (lo_to_hi_p != 0) begin : g_lo_end
      assign w_chain[0] = 1'b0;
      assign w_any      = w_chain[inputs_p];
    end else begin : g_hi_end
      assign w_chain[inputs_p] = 1'b0;
      assign w_any             = w_chain[0];
    end

    for (genvar k = 0; k < inputs_p; k++) begin : g_lane
      localparam int IN_IDX  = (lo_to_hi_p != 0) ? k     : k + 1;
      localparam int OUT_IDX = (lo_to_hi_p != 0) ? k + 1 : k;
      bsg_arb_fixed_n_to_1_buffered_lane #(.width_p(width_p)) u_lane (
        .i_v      (v_i[k]),
        .i_hi_any (w_chain[IN_IDX]),
        .i_data   (w_data_in[k]),
        .o_grant  (w_grant[k]),
        .o_any    (w_chain[OUT_IDX]),
        .o_data   (w_data_msk[k])
      );
    end
  endgenerate

  // The slot frees up this cycle if empty or if its entry is being taken.
  assign w_enq_ok = ~r_v | ready_i;
  assign w_load   = w_any & w_enq_ok & ~reset_i;
  assign yumi_o   = w_grant & {inputs_p{w_enq_ok & ~reset_i}};

  always_comb begin
    w_data_sel = '0;
    w_tag_sel  = '0;
    for (int k = 0; k < inputs_p; k++) begin
      w_data_sel = w_data_sel | w_data_msk[k];
      if (w_grant[k]) w_tag_sel = w_tag_sel | tag_width_lp'(k);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_v    <= 1'b0;
      r_data <= '0;
      r_tag  <= '0;
    end else if (w_load) begin
      r_v    <= 1'b1;
      r_data <= w_data_sel;
      r_tag  <= w_tag_sel;
    end else if (r_v & ready_i) begin
      r_v    <= 1'b0;
    end
  end

  assign v_o    = r_v;
  assign data_o = r_data;
  assign tag_o  = r_tag;

`ifndef SYNTHESIS
  // A pending request may only drop once it has been dequeued.
  logic                r_chk_en;
  logic [inputs_p-1:0] r_chk_hold;
  always_ff @(posedge clk_i) begin
    r_chk_en   <= ~reset_i;
    r_chk_hold <= v_i & ~yumi_o;
    if (r_chk_en && !reset_i)
      assert ((r_chk_hold & ~v_i) == '0)
        else $error("v_i dropped without yumi_o: %h", r_chk_hold & ~v_i);
  end
`endif

endmodule

// File: tb/tb_bsg_arb_fixed_n_to_1_buffered.sv
// Bench for the buffered fixed-priority merger: directed tables, hand-written
// stall/reset sequences, and a random run against a queue scoreboard.

module tb_bsg_arb_fixed_n_to_1_buffered;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [15:0]           vin  [2];
  logic [15:0][31:0]     din  [2];
  logic                  rdy  [2];
  logic [15:0]           yumi [2];
  logic                  vo   [2];
  logic [31:0]           dout [2];
  logic [3:0]            tout [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bsg_arb_fixed_n_to_1_buffered #(.inputs_p(16), .width_p(32), .lo_to_hi_p(0)) u_hi (
    .clk_i(clk), .reset_i(reset), .v_i(vin[0]), .data_i(din[0]), .yumi_o(yumi[0]),
    .v_o(vo[0]), .data_o(dout[0]), .tag_o(tout[0]), .ready_i(rdy[0]));

  bsg_arb_fixed_n_to_1_buffered #(.inputs_p(16), .width_p(32), .lo_to_hi_p(1)) u_lo (
    .clk_i(clk), .reset_i(reset), .v_i(vin[1]), .data_i(din[1]), .yumi_o(yumi[1]),
    .v_o(vo[1]), .data_o(dout[1]), .tag_o(tout[1]), .ready_i(rdy[1]));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Winner index by the priority rule, -1 when nothing is valid.
  function automatic int winner(input int d, input logic [15:0] v);
    if (d == 1) begin
      for (int i = 0; i < 16; i++) if (v[i]) return i;
    end else begin
      for (int i = 15; i >= 0; i--) if (v[i]) return i;
    end
    return -1;
  endfunction

  typedef struct {
    int          dut;
    logic [15:0] v;
    logic        r;
    logic [15:0] ey;
    logic        ev;
    logic [3:0]  et;
    logic [31:0] ed;
  } vec_t;

  vec_t        tbl [11];
  logic [35:0] sb [2][$];
  logic        mv [2];
  logic [15:0] last_y [2];
  logic [31:0] lane15;

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      vin[d] = '0; rdy[d] = 1'b0;
      for (int k = 0; k < 16; k++) din[d][k] = 32'hC0DE_0000 | k;
    end

    tbl[0]  = '{0, 16'h8101, 1'b1, 16'h8000, 1'b0, 4'd0,  32'h0};
    tbl[1]  = '{0, 16'h0101, 1'b1, 16'h0100, 1'b1, 4'd15, 32'hC0DE_000F};
    tbl[2]  = '{0, 16'h0001, 1'b1, 16'h0001, 1'b1, 4'd8,  32'hC0DE_0008};
    tbl[3]  = '{0, 16'h0000, 1'b1, 16'h0000, 1'b1, 4'd0,  32'hC0DE_0000};
    tbl[4]  = '{0, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'd0,  32'hC0DE_0000};
    tbl[5]  = '{1, 16'h0006, 1'b0, 16'h0002, 1'b0, 4'd0,  32'h0};
    tbl[6]  = '{1, 16'h0004, 1'b0, 16'h0000, 1'b1, 4'd1,  32'hC0DE_0001};
    tbl[7]  = '{1, 16'h0004, 1'b0, 16'h0000, 1'b1, 4'd1,  32'hC0DE_0001};
    tbl[8]  = '{1, 16'h0004, 1'b1, 16'h0004, 1'b1, 4'd1,  32'hC0DE_0001};
    tbl[9]  = '{1, 16'h0000, 1'b1, 16'h0000, 1'b1, 4'd2,  32'hC0DE_0002};
    tbl[10] = '{1, 16'h0000, 1'b1, 16'h0000, 1'b0, 4'd2,  32'hC0DE_0002};

    // Reset state, then idle for 10 cycles.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      for (int d = 0; d < 2; d++) begin
        chk("rst_vo", vo[d], 0);
        chk("rst_yumi", yumi[d], 0);
        chk("rst_data", dout[d], 0);
        chk("rst_tag", tout[d], 0);
      end
    end

    // Directed priority/throughput vectors for both directions.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin vin[d] = '0; rdy[d] = 1'b0; end
      vin[tbl[i].dut] = tbl[i].v;
      rdy[tbl[i].dut] = tbl[i].r;
      #1;
      chk($sformatf("tbl%0d_yumi", i), yumi[tbl[i].dut], tbl[i].ey);
      chk($sformatf("tbl%0d_vo", i),   vo[tbl[i].dut],   tbl[i].ev);
      chk($sformatf("tbl%0d_tag", i),  tout[tbl[i].dut], tbl[i].et);
      chk($sformatf("tbl%0d_data", i), dout[tbl[i].dut], tbl[i].ed);
    end

    // Stall: output must hold while other requesters' data churns.
    @(negedge clk);
    vin[0] = 16'h0008; din[0][3] = 32'hDEAD_BEEF; rdy[0] = 1'b0; #1;
    chk("stall_grant", yumi[0], 16'h0008);
    @(negedge clk);
    vin[0] = 16'h0020; din[0][5] = 32'h0000_0055; #1;
    chk("stall_yumi", yumi[0], 0);
    chk("stall_vo", vo[0], 1);
    chk("stall_tag", tout[0], 3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int k = 0; k < 16; k++) if (k != 5) din[0][k] = $urandom;
      #1;
      chk("stall_hold_yumi", yumi[0], 0);
      chk("stall_hold_data", dout[0], 32'hDEAD_BEEF);
      chk("stall_hold_tag", tout[0], 3);
    end
    @(negedge clk);
    rdy[0] = 1'b1; #1;
    chk("release_yumi", yumi[0], 16'h0020);
    chk("release_data", dout[0], 32'hDEAD_BEEF);
    @(negedge clk);
    vin[0] = '0; rdy[0] = 1'b0; #1;
    chk("release_tag", tout[0], 5);
    chk("release_data2", dout[0], 32'h55);

    // Reset while full with all requesters pending.
    @(negedge clk);
    vin[0] = 16'hFFFF; reset = 1'b1; #1;
    chk("midrst_yumi", yumi[0], 0);
    @(negedge clk);
    reset = 1'b0; lane15 = din[0][15]; #1;
    chk("postrst_vo", vo[0], 0);
    chk("postrst_data", dout[0], 0);
    chk("postrst_yumi", yumi[0], 16'h8000);
    @(negedge clk);
    vin[0] = 16'h7FFF; #1;
    chk("resume_vo", vo[0], 1);
    chk("resume_tag", tout[0], 15);
    chk("resume_data", dout[0], lane15);
    chk("resume_stall_yumi", yumi[0], 0);

    // Random run against the scoreboard model.
    @(negedge clk);
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      vin[d] = '0; rdy[d] = 1'b0; mv[d] = 1'b0; last_y[d] = '0;
      sb[d].delete();
    end
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < 16; k++) begin
          if (!vin[d][k] || last_y[d][k]) begin
            if ($urandom_range(4) <= (c / 500) % 4) begin
              vin[d][k] = 1'b1; din[d][k] = $urandom;
            end else begin
              vin[d][k] = 1'b0;
            end
          end
        end
        rdy[d] = ($urandom_range(3) != 0);
      end
      #1;
      for (int d = 0; d < 2; d++) begin
        int          w;
        logic [15:0] ey;
        logic [35:0] it;
        w  = winner(d, vin[d]);
        ey = (w >= 0 && (!mv[d] || rdy[d])) ? (16'(1) << w) : 16'h0;
        chk("rnd_yumi", yumi[d], ey);
        chk("rnd_onehot", ($countones(yumi[d]) <= 1), 1);
        chk("rnd_vo", vo[d], mv[d]);
        if (vo[d] && rdy[d]) begin
          if (sb[d].size() == 0) begin
            chk("rnd_sb_empty", 1, 0);
          end else begin
            it = sb[d].pop_front();
            chk("rnd_item", {dout[d], tout[d]}, it);
          end
        end
        if (w >= 0 && ey != 0) sb[d].push_back({din[d][w], 4'(w)});
        if (ey != 0)          mv[d] = 1'b1;
        else if (mv[d] && rdy[d]) mv[d] = 1'b0;
        last_y[d] = ey;
      end
    end
    #1;
    for (int d = 0; d < 2; d++) chk("rnd_sb_left", sb[d].size(), (mv[d] ? 1 : 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
